// File: rtl/stf_plateau_ctrl.sv
// STF plateau detection controller for the 16-sample delay-and-correlate front end.
// Optional gap tolerance inside a plateau is enabled by defining STF_PLATEAU_DROP_TOL_EN.
module stf_plateau_ctrl #(
  parameter int unsigned CORR_W       = 32,
  parameter int unsigned PWR_W        = 32,
  parameter int unsigned THRESH_NUM   = 3,
  parameter int unsigned THRESH_SHIFT = 2,
  parameter int unsigned WARMUP_LEN   = 16,
  parameter int unsigned PLATEAU_LEN  = 48,
  parameter int unsigned HOLDOFF_LEN  = 320
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enable_in,
  input  logic              sample_valid_in,
  input  logic [CORR_W-1:0] corr_mag_in,
  input  logic [PWR_W-1:0]  power_in,
  output logic              detect_out,
  output logic              busy_out,
  output logic [1:0]        state_out,
  output logic [7:0]        drops_out
);

  localparam logic [1:0] StWarmup  = 2'd0;
  localparam logic [1:0] StSearch  = 2'd1;
  localparam logic [1:0] StPlateau = 2'd2;
  localparam logic [1:0] StHoldoff = 2'd3;

  // Compare width wide enough that neither product nor shift can overflow.
  localparam int unsigned QW = (CORR_W + THRESH_SHIFT > PWR_W + 8) ?
                               (CORR_W + THRESH_SHIFT) : (PWR_W + 8);
  localparam int unsigned WW = (WARMUP_LEN  < 1) ? 1 : $clog2(WARMUP_LEN + 1);
  localparam int unsigned PW = (PLATEAU_LEN < 1) ? 1 : $clog2(PLATEAU_LEN + 1);
  localparam int unsigned HW = (HOLDOFF_LEN < 1) ? 1 : $clog2(HOLDOFF_LEN + 1);

  localparam logic [7:0] ThreshNum = THRESH_NUM[7:0];

  logic [QW-1:0] lhs, rhs;
  logic          qual;

  assign lhs  = QW'(corr_mag_in) << THRESH_SHIFT;
  assign rhs  = QW'(power_in) * QW'(ThreshNum);
  assign qual = (lhs >= rhs);

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [PW-1:0] plat_q, plat_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          detect_q, detect_d;
  logic          busy_q, busy_d;
  logic          fire;

`ifdef STF_PLATEAU_DROP_TOL_EN
  logic [1:0]    gap_q, gap_d;
  logic [7:0]    drops_q, drops_d;
`endif

  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    plat_d   = plat_q;
    hold_d   = hold_q;
    detect_d = 1'b0;
    fire     = 1'b0;
`ifdef STF_PLATEAU_DROP_TOL_EN
    gap_d    = gap_q;
    drops_d  = drops_q;
`endif

    if (!enable_in) begin
      state_d = StWarmup;
      warm_d  = '0;
      plat_d  = '0;
      hold_d  = '0;
`ifdef STF_PLATEAU_DROP_TOL_EN
      gap_d   = '0;
`endif
    end else if (sample_valid_in) begin
      case (state_q)
        StWarmup: begin
          // The sample that completes warm-up is consumed, not evaluated.
          if (32'(warm_q) + 32'd1 >= WARMUP_LEN) begin
            state_d = StSearch;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + WW'(1);
          end
        end
        StSearch: begin
          if (qual) begin
`ifdef STF_PLATEAU_DROP_TOL_EN
            gap_d = '0;
`endif
            if (PLATEAU_LEN <= 1) begin
              fire = 1'b1;
            end else begin
              plat_d  = PW'(1);
              state_d = StPlateau;
            end
          end
        end
        StPlateau: begin
          if (qual) begin
            if (32'(plat_q) + 32'd1 >= PLATEAU_LEN) begin
              fire = 1'b1;
            end else begin
              plat_d = plat_q + PW'(1);
            end
          end else begin
`ifdef STF_PLATEAU_DROP_TOL_EN
            // Up to two gaps are tolerated; the third abandons the plateau.
            if (gap_q >= 2'd2) begin
              state_d = StSearch;
              plat_d  = '0;
              gap_d   = '0;
            end else begin
              gap_d = gap_q + 2'd1;
            end
`else
            state_d = StSearch;
            plat_d  = '0;
`endif
          end
        end
        StHoldoff: begin
          if (32'(hold_q) + 32'd1 >= HOLDOFF_LEN) begin
            state_d = StSearch;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: begin
          state_d = StWarmup;
        end
      endcase

      if (fire) begin
        detect_d = 1'b1;
        state_d  = StHoldoff;
        plat_d   = '0;
        hold_d   = '0;
`ifdef STF_PLATEAU_DROP_TOL_EN
        drops_d  = {6'd0, gap_q};
        gap_d    = '0;
`endif
      end
    end

    busy_d = (state_d == StPlateau) || (state_d == StHoldoff);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= StWarmup;
      warm_q   <= '0;
      plat_q   <= '0;
      hold_q   <= '0;
      detect_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef STF_PLATEAU_DROP_TOL_EN
      gap_q    <= '0;
      drops_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      plat_q   <= plat_d;
      hold_q   <= hold_d;
      detect_q <= detect_d;
      busy_q   <= busy_d;
`ifdef STF_PLATEAU_DROP_TOL_EN
      gap_q    <= gap_d;
      drops_q  <= drops_d;
`endif
    end
  end

  assign detect_out = detect_q;
  assign busy_out   = busy_q;
  assign state_out  = state_q;
`ifdef STF_PLATEAU_DROP_TOL_EN
  assign drops_out  = drops_q;
`else
  assign drops_out  = 8'd0;
`endif

endmodule

// File: doc/stf_plateau_ctrl.md
Name: stf_plateau_ctrl

Overview:
- Detection controller for the 16-sample delay-and-correlate front end of the CSI extractor.
- Consumes per-sample correlation magnitude and window power from the correlator that sits on the sample delay line.
- Waits until that delay line is primed, then searches for an STF plateau (sustained correlation above a power-scaled threshold).
- On a plateau it emits a one-cycle packet-detect pulse, then holds off for a configured number of samples before re-arming.

Parameters:
- CORR_W, 32, width of the unsigned correlation magnitude input
- PWR_W, 32, width of the unsigned window power input
- THRESH_NUM, 3, threshold numerator (unsigned, 8-bit range 1..255)
- THRESH_SHIFT, 2, threshold denominator as 2^THRESH_SHIFT (default ratio 0.75)
- WARMUP_LEN, 16, valid samples ignored after reset or re-enable while the delay line fills
- PLATEAU_LEN, 48, consecutive qualifying valid samples required for detection (>=1)
- HOLDOFF_LEN, 320, valid samples ignored after a detection (>=1)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-low
- enable_in  input  1  controller enable; low forces WARMUP and clears counters
- sample_valid_in  input  1  corr_mag_in and power_in valid this cycle
- corr_mag_in  input  CORR_W  correlation magnitude
- power_in  input  PWR_W  window power
- detect_out  output  1  one-cycle detection pulse
- busy_out  output  1  high in PLATEAU or HOLDOFF
- state_out  output  2  current state: WARMUP=0, SEARCH=1, PLATEAU=2, HOLDOFF=3
- drops_out  output  8  qualifying-gap count of the last detection; 0 when the optional feature is off

Behaviour:
- Reset (rst_in low at a clock edge):
  - state=WARMUP; all counters 0.
  - detect_out=0, busy_out=0, state_out=0, drops_out=0.
  - Reset takes priority over everything, including mid-plateau and mid-holdoff.
- Qualify (combinational): qual = (corr_mag_in << THRESH_SHIFT) >= (power_in * THRESH_NUM).
  - Both sides are zero-extended to max(CORR_W+THRESH_SHIFT, PWR_W+8) bits; no truncation.
  - power_in=0 with corr_mag_in=0 qualifies.
- State and counters change only on cycles with sample_valid_in=1. With valid low, everything holds and detect_out=0.
- enable_in low: next state WARMUP, counters cleared, detect_out=0. enable_in low overrides sample_valid_in.
- WARMUP:
  - Count valid samples.
  - On the WARMUP_LEN-th valid sample, go to SEARCH. That sample is not evaluated.
- SEARCH:
  - Valid and qual: plateau count=1, go to PLATEAU.
  - If PLATEAU_LEN==1, detect instead (see PLATEAU).
- PLATEAU:
  - Valid and qual: count+1.
  - Valid and not qual: count=0, go to SEARCH.
  - When the count reaches PLATEAU_LEN: register detect_out=1 for exactly one cycle (the cycle after that sample's edge), go to HOLDOFF, holdoff count=0.
- HOLDOFF:
  - Count valid samples; qual is ignored.
  - On the HOLDOFF_LEN-th valid sample, go to SEARCH. No detection is possible in HOLDOFF.
- Latency: detect_out rises 1 clock after the edge sampling the PLATEAU_LEN-th qualifying sample.
- busy_out and state_out are registered and track the state.
- Counter widths are sized from their parameters; counters saturate-free because they never exceed their limit.
- Back-to-back valid every cycle is supported with no bubbles.

Optional Feature:
- Macro: STF_PLATEAU_DROP_TOL_EN.
- When defined:
  - In PLATEAU, a non-qualifying sample increments a gap counter instead of returning to SEARCH. The plateau count holds on such a sample.
  - Return to SEARCH only when gaps exceed 2 within the current plateau.
  - The gap counter clears on entry to PLATEAU.
  - drops_out latches the gap count on each detection and holds it until the next detection or reset.
- When undefined: any non-qualifying sample in PLATEAU returns to SEARCH, and drops_out is tied to 0.

Test Plan:
- Reset then 16 valid samples with corr=100, power=100 -> state_out=0 throughout, then 1; no detect_out.
- After warmup, 48 consecutive valid samples with corr=75, power=100 (75*4=300 >= 300) -> detect_out high for exactly 1 cycle after the 48th sample; state_out=3; busy_out=1.
- After warmup, 47 qualifying samples, then corr=74, power=100 -> state_out returns to 1, no detect; a further 48 qualifying samples -> detect.
- After a detection, 320 valid samples of strong correlation -> no second detect; state_out=1 after the 320th; 48 more qualifying samples -> second detect.
- Qualifying stream with sample_valid_in toggling 1,0,1,0 -> detect only after 48 valid samples; enable_in pulled low mid-PLATEAU -> state_out=0, next detect requires 16+48 valid samples.
- With STF_PLATEAU_DROP_TOL_EN: 20 qualifying samples, 2 non-qualifying, 28 qualifying -> detect with drops_out=2; with 3 non-qualifying -> no detect, state_out=1.
